pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 156 +++++++++++++++
 tb/tb_pwm_capture.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in i_clk cycles.
// Latency: P_SYNC+1 rising i_clk edges from the first edge sampling i_pwm high to o_valid.
// Backpressure: none; o_valid is a one-cycle strobe and results hold until the next capture.
//
// Ports:
//   i_clk      single clock, all state on its rising edge
//   i_rst_n    asynchronous active-low reset (deassertion synchronized internally)
//   i_en       capture enable; low forces IDLE and clears the counters
//   i_pwm      asynchronous PWM signal under measurement
//   o_period   last measured period in i_clk cycles
//   o_high     last measured high time in i_clk cycles
//   o_valid    one-cycle strobe marking a new o_period/o_high pair
//   o_timeout  level, set when the period counter saturates, cleared by the next o_valid
module pwm_capture #(
    parameter int P_WIDTH = 16,
    parameter int P_SYNC  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_pwm,
    output logic [P_WIDTH-1:0] o_period,
    output logic [P_WIDTH-1:0] o_high,
    output logic               o_valid,
    output logic               o_timeout
);

    // Fewer than two synchronizer stages is not metastability-safe; clamp it.
    localparam int LP_SYNC = (P_SYNC < 2) ? 2 : P_SYNC;

    localparam logic [P_WIDTH-1:0] LP_MAX = '1;
    localparam logic [P_WIDTH-1:0] LP_ONE = P_WIDTH'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    // Reset: asserts asynchronously, releases two clock edges after i_rst_n rises.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Input synchronizer and edge detection; runs regardless of i_en.
    logic [LP_SYNC-1:0] r_sync;
    logic               r_s_pwm_d;
    logic               w_s_pwm;
    logic               w_rise;
    logic               w_fall;

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sync    <= '0;
            r_s_pwm_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[LP_SYNC-2:0], i_pwm};
            r_s_pwm_d <= r_sync[LP_SYNC-1];
        end
    end

    assign w_s_pwm = r_sync[LP_SYNC-1];
    assign w_rise  = w_s_pwm & ~r_s_pwm_d;
    assign w_fall  = ~w_s_pwm & r_s_pwm_d;

    // Measurement FSM
    logic [1:0]         r_state;
    logic [P_WIDTH-1:0] r_cnt_period;
    logic [P_WIDTH-1:0] r_cnt_high;
    logic [P_WIDTH-1:0] r_period;
    logic [P_WIDTH-1:0] r_high;
    logic               r_valid;
    logic               r_timeout;

    always_ff @(posedge i_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt_period <= '0;
            r_cnt_high   <= '0;
            r_period     <= '0;
            r_high       <= '0;
            r_valid      <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (!i_en) begin
                // Disable beats any edge seen this cycle; results and timeout hold.
                r_state      <= ST_IDLE;
                r_cnt_period <= '0;
                r_cnt_high   <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_rise) begin
                            r_cnt_period <= LP_ONE;
                            r_cnt_high   <= LP_ONE;
                            r_state      <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (r_cnt_period == LP_MAX) begin
                            r_state      <= ST_IDLE;
                            r_cnt_period <= '0;
                            r_cnt_high   <= '0;
                            r_timeout    <= 1'b1;
                        end else if (w_fall) begin
                            // The falling-edge cycle is already low: period only.
                            r_cnt_period <= r_cnt_period + LP_ONE;
                            r_state      <= ST_LOW;
                        end else begin
                            r_cnt_period <= r_cnt_period + LP_ONE;
                            r_cnt_high   <= r_cnt_high + LP_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (w_rise) begin
                            // Capture pre-increment counts; this rise opens the next period.
                            r_period     <= r_cnt_period;
                            r_high       <= r_cnt_high;
                            r_valid      <= 1'b1;
                            r_timeout    <= 1'b0;
                            r_cnt_period <= LP_ONE;
                            r_cnt_high   <= LP_ONE;
                            r_state      <= ST_HIGH;
                        end else if (r_cnt_period == LP_MAX) begin
                            r_state      <= ST_IDLE;
                            r_cnt_period <= '0;
                            r_cnt_high   <= '0;
                            r_timeout    <= 1'b1;
                        end else begin
                            r_cnt_period <= r_cnt_period + LP_ONE;
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_cnt_period <= '0;
                        r_cnt_high   <= '0;
                    end
                endcase
            end
        end
    end

    assign o_period  = r_period;
    assign o_high    = r_high;
    assign o_valid   = r_valid;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed checks of pwm_capture at P_WIDTH=16 and P_WIDTH=8.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_en = 1'b1;
    logic        i_pwm = 1'b0;

    logic [15:0] o_period16;
    logic [15:0] o_high16;
    logic        o_valid16;
    logic        o_timeout16;
    logic [7:0]  o_period8;
    logic [7:0]  o_high8;
    logic        o_valid8;
    logic        o_timeout8;

    int total = 0;
    int bad   = 0;

    // Recorded valid events from the 16-bit instance, indexed by tick number.
    int v_idx[$];
    int v_per[$];
    int v_hi[$];
    int v8_cnt;
    int tidx;

    always #5 clk = ~clk;

    pwm_capture #(.P_WIDTH(16), .P_SYNC(2)) dut16 (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_pwm     (i_pwm),
        .o_period  (o_period16),
        .o_high    (o_high16),
        .o_valid   (o_valid16),
        .o_timeout (o_timeout16)
    );

    pwm_capture #(.P_WIDTH(8), .P_SYNC(2)) dut8 (
        .i_clk     (clk),
        .i_rst_n   (i_rst_n),
        .i_en      (i_en),
        .i_pwm     (i_pwm),
        .o_period  (o_period8),
        .o_high    (o_high8),
        .o_valid   (o_valid8),
        .o_timeout (o_timeout8)
    );

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic tick(input logic p);
        i_pwm = p;
        @(posedge clk);
        #1;
        if (o_valid16) begin
            v_idx.push_back(tidx);
            v_per.push_back(int'(o_period16));
            v_hi.push_back(int'(o_high16));
        end
        if (o_valid8) v8_cnt++;
        tidx++;
    endtask

    task automatic run_wave(input int per, input int hi, input int n);
        for (int p = 0; p < n; p++)
            for (int c = 0; c < per; c++)
                tick(c < hi);
    endtask

    task automatic clear_rec();
        v_idx.delete();
        v_per.delete();
        v_hi.delete();
        v8_cnt = 0;
        tidx   = 0;
    endtask

    // Assumes i_rst_n is low on entry; releases it and lets the reset synchronizer settle.
    task automatic do_reset();
        i_en  = 1'b1;
        i_pwm = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        i_rst_n = 1'b1;
        repeat (4) tick(1'b0);
        clear_rec();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #1;
        total++;
        if ({o_period16, o_high16, o_valid16, o_timeout16} !== 34'd0) begin
            bad++;
            $display("FAIL reset16: got per=%0d hi=%0d v=%0b to=%0b, want all 0",
                     o_period16, o_high16, o_valid16, o_timeout16);
        end
        total++;
        if ({o_period8, o_high8, o_valid8, o_timeout8} !== 18'd0) begin
            bad++;
            $display("FAIL reset8: got per=%0d hi=%0d v=%0b to=%0b, want all 0",
                     o_period8, o_high8, o_valid8, o_timeout8);
        end
        do_reset();
    endtask

    task automatic test_square();
        int errs;
        run_wave(10, 3, 5);
        total++;
        if (v_idx.size() != 4) begin
            bad++;
            $display("FAIL square_count: got %0d valids, want 4", v_idx.size());
        end
        total++;
        if (v_idx.size() < 1 || v_idx[0] != 12) begin
            bad++;
            $display("FAIL square_latency: first valid at tick %0d, want 12",
                     (v_idx.size() > 0) ? v_idx[0] : -1);
        end
        errs = 0;
        for (int i = 0; i < v_idx.size(); i++) begin
            if (v_per[i] != 10 || v_hi[i] != 3) errs++;
            if (i > 0 && v_idx[i] - v_idx[i-1] != 10) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL square_values: %0d bad entries, want per=10 hi=3 every 10 ticks", errs);
        end
    endtask

    // Continues from test_square without reset.
    task automatic test_period_change();
        int base;
        base = v_idx.size();
        run_wave(20, 15, 3);
        total++;
        if (v_idx.size() - base != 3) begin
            bad++;
            $display("FAIL change_count: got %0d valids, want 3", v_idx.size() - base);
        end else begin
            total++;
            if (v_per[base] != 10 || v_hi[base] != 3 || v_idx[base] != 52) begin
                bad++;
                $display("FAIL change_old: got %0d/%0d at %0d, want 10/3 at 52",
                         v_per[base], v_hi[base], v_idx[base]);
            end
            for (int i = base + 1; i < base + 3; i++) begin
                total++;
                if (v_per[i] != 20 || v_hi[i] != 15) begin
                    bad++;
                    $display("FAIL change_new: got %0d/%0d, want 20/15", v_per[i], v_hi[i]);
                end
            end
        end
    endtask

    task automatic test_pulses();
        int errs;
        i_rst_n = 1'b0;
        do_reset();
        run_wave(4, 1, 6);
        total++;
        if (v_idx.size() != 5) begin
            bad++;
            $display("FAIL pulse4_count: got %0d, want 5", v_idx.size());
        end
        errs = 0;
        for (int i = 0; i < v_idx.size(); i++)
            if (v_per[i] != 4 || v_hi[i] != 1) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL pulse4_values: %0d bad entries, want 4/1", errs);
        end
        // Minimum reportable period: 1 high, 1 low.
        i_rst_n = 1'b0;
        do_reset();
        run_wave(2, 1, 6);
        total++;
        if (v_idx.size() != 4) begin
            bad++;
            $display("FAIL pulse2_count: got %0d, want 4", v_idx.size());
        end
        errs = 0;
        for (int i = 0; i < v_idx.size(); i++)
            if (v_per[i] != 2 || v_hi[i] != 1) errs++;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL pulse2_values: %0d bad entries, want 2/1", errs);
        end
    endtask

    task automatic test_timeout();
        i_rst_n = 1'b0;
        do_reset();
        run_wave(10, 3, 2);
        // Rise at tick 20 enters HIGH at the edge of tick 22; 255 edges later is tick 277.
        while (tidx <= 276) tick(1'b1);
        total++;
        if (o_timeout8 !== 1'b0) begin
            bad++;
            $display("FAIL timeout_early: got %0b at tick 276, want 0", o_timeout8);
        end
        tick(1'b1);
        total++;
        if (o_timeout8 !== 1'b1) begin
            bad++;
            $display("FAIL timeout_set: got %0b at tick 277, want 1", o_timeout8);
        end
        repeat (10) tick(1'b1);
        total++;
        if (o_timeout8 !== 1'b1 || v8_cnt != 2) begin
            bad++;
            $display("FAIL timeout_hold: to=%0b valids=%0d, want to=1 valids=2", o_timeout8, v8_cnt);
        end
        total++;
        if (o_period8 !== 8'd10 || o_high8 !== 8'd3) begin
            bad++;
            $display("FAIL timeout_results: got %0d/%0d, want 10/3", o_period8, o_high8);
        end
        total++;
        if (o_timeout16 !== 1'b0) begin
            bad++;
            $display("FAIL timeout_wide: got %0b, want 0", o_timeout16);
        end
        // Recovery: first rise only starts a period; the next completes it and clears timeout.
        repeat (5) tick(1'b0);
        for (int c = 0; c < 20; c++) begin
            tick((c % 10) < 3);
            if (c == 11) begin
                total++;
                if (o_timeout8 !== 1'b1) begin
                    bad++;
                    $display("FAIL timeout_sticky: got %0b before capture, want 1", o_timeout8);
                end
            end
            if (c == 12) begin
                total++;
                if (o_timeout8 !== 1'b0 || o_valid8 !== 1'b1) begin
                    bad++;
                    $display("FAIL timeout_clear: to=%0b v=%0b, want to=0 v=1", o_timeout8, o_valid8);
                end
            end
        end
    endtask

    task automatic test_reset_mid_low();
        i_rst_n = 1'b0;
        do_reset();
        run_wave(10, 3, 1);
        for (int c = 0; c < 8; c++) tick(c < 3);
        total++;
        if (o_period16 !== 16'd10 || o_high16 !== 16'd3) begin
            bad++;
            $display("FAIL midlow_pre: got %0d/%0d, want 10/3", o_period16, o_high16);
        end
        i_rst_n = 1'b0;
        #1;
        total++;
        if ({o_period16, o_high16, o_valid16, o_timeout16} !== 34'd0) begin
            bad++;
            $display("FAIL midlow_clear: got per=%0d hi=%0d v=%0b to=%0b, want all 0",
                     o_period16, o_high16, o_valid16, o_timeout16);
        end
        do_reset();
        run_wave(10, 3, 3);
        total++;
        if (v_idx.size() != 2 || v_idx[0] != 12) begin
            bad++;
            $display("FAIL midlow_restart: got %0d valids first at %0d, want 2 first at 12",
                     v_idx.size(), (v_idx.size() > 0) ? v_idx[0] : -1);
        end
    endtask

    task automatic test_enable();
        i_rst_n = 1'b0;
        do_reset();
        for (int c = 0; c < 80; c++) begin
            if (c == 25) i_en = 1'b0;
            if (c == 30) i_en = 1'b1;
            tick((c % 20) < 15);
            if (c == 29) begin
                total++;
                if (o_period16 !== 16'd20 || o_high16 !== 16'd15 || o_valid16 !== 1'b0) begin
                    bad++;
                    $display("FAIL en_hold: got %0d/%0d v=%0b, want 20/15 v=0",
                             o_period16, o_high16, o_valid16);
                end
            end
        end
        total++;
        if (v_idx.size() != 2) begin
            bad++;
            $display("FAIL en_count: got %0d valids, want 2", v_idx.size());
        end else begin
            total++;
            if (v_idx[0] != 22 || v_idx[1] != 62 || v_per[1] != 20 || v_hi[1] != 15) begin
                bad++;
                $display("FAIL en_resume: got %0d,%0d with %0d/%0d, want 22,62 with 20/15",
                         v_idx[0], v_idx[1], v_per[1], v_hi[1]);
            end
        end
    endtask

    initial begin
        clear_rec();
        test_reset();
        test_square();
        test_period_change();
        test_pulses();
        test_timeout();
        test_reset_mid_low();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
